// File: rtl/conv2_scheduler.sv
// Single-MAC 2-D valid convolution sequencer: K2+2 cycles per output, OUT*OUT*(K2+2) per pass, start ignored while busy.
// Optional CONV2_SCHED_RELU_EN clamps negative saturated results to zero; timing is unchanged.
module conv2_scheduler #(
  parameter int SIZE      = 8,
  parameter int SIZEKer   = 3,
  parameter int WIDTH_BIT = 16
) (
  input  logic                                                clock,
  input  logic                                                nreset,
  input  logic                                                start,
  output logic                                                busy,
  output logic                                                done,
  output logic                                                img_rd,
  output logic [$clog2(SIZE*SIZE)-1:0]                        img_addr,
  input  logic [WIDTH_BIT-1:0]                                img_data,
  output logic                                                ker_rd,
  output logic [$clog2(SIZEKer*SIZEKer)-1:0]                  ker_addr,
  input  logic [WIDTH_BIT-1:0]                                ker_data,
  output logic                                                out_we,
  output logic [$clog2((SIZE-SIZEKer+1)*(SIZE-SIZEKer+1))-1:0] out_addr,
  output logic [WIDTH_BIT-1:0]                                out_data
);
  localparam int K2   = SIZEKer * SIZEKer;
  localparam int OUT  = SIZE - SIZEKer + 1;
  localparam int IAW  = $clog2(SIZE * SIZE);
  localparam int KAW  = $clog2(K2);
  localparam int OAW  = $clog2(OUT * OUT);
  localparam int W    = WIDTH_BIT;
  localparam int ACCW = 2 * W + $clog2(K2);
  localparam int KCW  = $clog2(SIZEKer + 1);
  localparam int OCW  = $clog2(OUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_WRITE, S_FINISH} state_t;

  state_t                  r_state;
  logic [KCW-1:0]          r_kr, r_kc;
  logic [OCW-1:0]          r_r, r_c;
  logic                    r_tap_vld, r_tap_first;
  logic signed [ACCW-1:0]  r_acc;

  logic                    w_last_kc, w_last_kr, w_last_c, w_last_r;
  logic [KCW-1:0]          w_kc_nxt, w_kr_nxt;
  logic [OCW-1:0]          w_c_nxt, w_r_nxt;
  logic signed [2*W-1:0]   w_prod;
  logic signed [ACCW-1:0]  w_acc_next;
  logic [ACCW-W:0]         w_top;
  logic [W-1:0]            w_sat, w_res;

  function automatic logic [IAW-1:0] img_a(input logic [OCW-1:0] r, input logic [OCW-1:0] c,
                                           input logic [KCW-1:0] kr, input logic [KCW-1:0] kc);
    return IAW'((int'(r) + int'(kr)) * SIZE + int'(c) + int'(kc));
  endfunction

  function automatic logic [KAW-1:0] ker_a(input logic [KCW-1:0] kr, input logic [KCW-1:0] kc);
    return KAW'(int'(kr) * SIZEKer + int'(kc));
  endfunction

  assign w_last_kc = (r_kc == KCW'(SIZEKer - 1));
  assign w_last_kr = (r_kr == KCW'(SIZEKer - 1));
  assign w_last_c  = (r_c == OCW'(OUT - 1));
  assign w_last_r  = (r_r == OCW'(OUT - 1));
  assign w_kc_nxt  = w_last_kc ? '0 : r_kc + 1'b1;
  assign w_kr_nxt  = w_last_kc ? r_kr + 1'b1 : r_kr;
  assign w_c_nxt   = w_last_c ? '0 : r_c + 1'b1;
  assign w_r_nxt   = w_last_c ? r_r + 1'b1 : r_r;

  // Tap 0 loads the accumulator directly, so no clear cycle is needed between outputs.
  assign w_prod     = $signed(img_data) * $signed(ker_data);
  assign w_acc_next = r_tap_first ? {{(ACCW-2*W){w_prod[2*W-1]}}, w_prod}
                                  : r_acc + {{(ACCW-2*W){w_prod[2*W-1]}}, w_prod};
  assign w_top      = w_acc_next[ACCW-1:W-1];

  always_comb begin
    w_sat = w_acc_next[W-1:0];
    if (!((&w_top) || !(|w_top)))
      w_sat = w_acc_next[ACCW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  end

`ifdef CONV2_SCHED_RELU_EN
  assign w_res = w_sat[W-1] ? '0 : w_sat;
`else
  assign w_res = w_sat;
`endif

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_state     <= S_IDLE;
      r_kr        <= '0;
      r_kc        <= '0;
      r_r         <= '0;
      r_c         <= '0;
      r_tap_vld   <= 1'b0;
      r_tap_first <= 1'b0;
      r_acc       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      img_rd      <= 1'b0;
      ker_rd      <= 1'b0;
      img_addr    <= '0;
      ker_addr    <= '0;
      out_we      <= 1'b0;
      out_addr    <= '0;
      out_data    <= '0;
    end else begin
      r_tap_vld   <= img_rd;
      r_tap_first <= img_rd && (ker_addr == '0);
      if (r_tap_vld) r_acc <= w_acc_next;
      case (r_state)
        S_IDLE, S_FINISH: begin
          if (start) begin
            r_state  <= S_FETCH;
            busy     <= 1'b1;
            done     <= 1'b0;
            r_r      <= '0;
            r_c      <= '0;
            r_kr     <= '0;
            r_kc     <= '0;
            img_rd   <= 1'b1;
            ker_rd   <= 1'b1;
            img_addr <= '0;
            ker_addr <= '0;
          end
        end
        S_FETCH: begin
          if (w_last_kc && w_last_kr) begin
            img_rd  <= 1'b0;
            ker_rd  <= 1'b0;
            r_kr    <= '0;
            r_kc    <= '0;
            r_state <= S_DRAIN;
          end else begin
            r_kr     <= w_kr_nxt;
            r_kc     <= w_kc_nxt;
            img_addr <= img_a(r_r, r_c, w_kr_nxt, w_kc_nxt);
            ker_addr <= ker_a(w_kr_nxt, w_kc_nxt);
          end
        end
        // Last tap's data arrives now; fold it in combinationally and register the result.
        S_DRAIN: begin
          out_we   <= 1'b1;
          out_data <= w_res;
          out_addr <= OAW'(int'(r_r) * OUT + int'(r_c));
          r_state  <= S_WRITE;
        end
        S_WRITE: begin
          out_we <= 1'b0;
          if (w_last_c && w_last_r) begin
            r_state <= S_FINISH;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            r_c      <= w_c_nxt;
            r_r      <= w_r_nxt;
            img_rd   <= 1'b1;
            ker_rd   <= 1'b1;
            img_addr <= img_a(w_r_nxt, w_c_nxt, KCW'(0), KCW'(0));
            ker_addr <= '0;
            r_state  <= S_FETCH;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
